// File: rtl/hub75_pkg.sv
// Shared constants, FSM state encoding and pixel-address helpers for the HUB75 scanner.
// The pixel address is {1'b0, ROW[4:0], COL[5:0]} and covers the full 64x32 panel.
package hub75_pkg;

    localparam int PANEL_COLS   = 64;
    localparam int PANEL_ROWS   = 32;
    localparam int SCAN_ROWS    = PANEL_ROWS / 2;
    localparam int ADDR_W       = 12;
    localparam int ADDR_ROW_MSB = 10;
    localparam int ADDR_ROW_LSB = 6;
    localparam int ADDR_COL_MSB = 5;
    localparam int ADDR_COL_LSB = 0;

    typedef enum logic [2:0] {
        S_ADDR_TOP,
        S_ADDR_BOT,
        S_SHIFT_SETUP,
        S_SHIFT_CLK,
        S_LATCH,
        S_DISPLAY,
        S_NEXT
    } state_t;

    function automatic logic [ADDR_W-1:0] make_addr(input logic       bottom,
                                                    input logic [3:0] row,
                                                    input logic [5:0] col);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[ADDR_ROW_MSB:ADDR_ROW_LSB] = {bottom, row};
        a[ADDR_COL_MSB:ADDR_COL_LSB] = col;
        return a;
    endfunction

    // Returns {R,G,B} bit idx of a packed {R[7:0],G[7:0],B[7:0]} pixel.
    function automatic logic [2:0] pick_rgb(input logic [23:0] px, input logic [2:0] idx);
        logic [23:0] s;
        s = px >> idx;
        return {s[16], s[8], s[0]};
    endfunction

endpackage

// File: rtl/hub75_scanner_bcm_timer.sv
// Binary-coded-modulation display timer: loads BCM_BASE<<plane on start and
// counts down, flagging done on the last cycle of the display window.
module bcm_timer
    import hub75_pkg::*;
#(
    parameter int PWM_BITS = 4,
    parameter int BCM_BASE = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [2:0] i_plane,
    output logic       o_done
);

    localparam int MAX_LEN = BCM_BASE << (PWM_BITS - 1);
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [CNT_W-1:0] w_load;

    assign w_load = (CNT_W'(BCM_BASE) << i_plane) - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= w_load;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_done = r_busy && (r_cnt == '0);

endmodule

// File: rtl/hub75_scanner.sv
// HUB75 64x32 1/16-scan panel driver with BCM grey levels.
// States: ADDR_TOP/ADDR_BOT fetch pixels, SHIFT_SETUP/SHIFT_CLK shift a column, LATCH, DISPLAY, NEXT.
module hub75_scanner
    import hub75_pkg::*;
#(
    parameter int PWM_BITS = 4,
    parameter int BCM_BASE = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] pixel_addr,
    input  logic [23:0] pixel_data,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic        r2,
    output logic        g2,
    output logic        b2,
    output logic [3:0]  row_sel,
    output logic        panel_clk,
    output logic        panel_lat,
    output logic        panel_oe_n,
    output logic        frame_start
);

    localparam logic [2:0] PLANE_LAST = 3'(PWM_BITS - 1);
    localparam logic [3:0] ROW_LAST   = 4'(SCAN_ROWS - 1);
    localparam logic [5:0] COL_LAST   = 6'(PANEL_COLS - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_row, w_row_nxt;
    logic [2:0]  r_plane, w_plane_nxt;
    logic [5:0]  r_col, w_col_nxt;
    logic [11:0] r_pixel_addr;
    logic [2:0]  r_top_rgb;
    logic [5:0]  r_rgb;
    logic [3:0]  r_row_sel;
    logic [2:0]  w_bit_idx;
    logic        w_bcm_start;
    logic        w_bcm_done;

    assign w_bit_idx   = 3'(8 - PWM_BITS) + r_plane;
    assign w_bcm_start = (r_state == S_LATCH);

    bcm_timer #(
        .PWM_BITS(PWM_BITS),
        .BCM_BASE(BCM_BASE)
    ) u_bcm_timer (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_bcm_start),
        .i_plane(r_plane),
        .o_done (w_bcm_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_plane_nxt = r_plane;
        w_col_nxt   = r_col;
        case (r_state)
            S_ADDR_TOP:    w_state_nxt = S_ADDR_BOT;
            S_ADDR_BOT:    w_state_nxt = S_SHIFT_SETUP;
            S_SHIFT_SETUP: w_state_nxt = S_SHIFT_CLK;
            S_SHIFT_CLK: begin
                w_col_nxt   = r_col + 6'd1;
                w_state_nxt = (r_col == COL_LAST) ? S_LATCH : S_ADDR_TOP;
            end
            S_LATCH:       w_state_nxt = S_DISPLAY;
            S_DISPLAY: begin
                if (w_bcm_done) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_col_nxt   = '0;
                w_state_nxt = S_ADDR_TOP;
                if (r_plane == PLANE_LAST) begin
                    w_plane_nxt = '0;
                    w_row_nxt   = (r_row == ROW_LAST) ? 4'd0 : r_row + 4'd1;
                end else begin
                    w_plane_nxt = r_plane + 3'd1;
                end
            end
            default:       w_state_nxt = S_ADDR_TOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_ADDR_TOP;
            r_row        <= '0;
            r_plane      <= '0;
            r_col        <= '0;
            r_pixel_addr <= '0;
            r_top_rgb    <= '0;
            r_rgb        <= '0;
            r_row_sel    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_plane <= w_plane_nxt;
            r_col   <= w_col_nxt;
            // Address is set up for the state being entered and held otherwise.
            if (w_state_nxt == S_ADDR_TOP) begin
                r_pixel_addr <= make_addr(1'b0, w_row_nxt, w_col_nxt);
            end else if (w_state_nxt == S_ADDR_BOT) begin
                r_pixel_addr <= make_addr(1'b1, w_row_nxt, w_col_nxt);
            end
            if (r_state == S_ADDR_TOP) begin
                r_top_rgb <= pick_rgb(pixel_data, w_bit_idx);
            end
            if (r_state == S_ADDR_BOT) begin
                r_rgb <= {r_top_rgb, pick_rgb(pixel_data, w_bit_idx)};
            end
            if (w_state_nxt == S_LATCH) begin
                r_row_sel <= r_row;
            end
        end
    end

    assign pixel_addr  = r_pixel_addr;
    assign {r1, g1, b1, r2, g2, b2} = r_rgb;
    assign row_sel     = r_row_sel;
    assign panel_clk   = (r_state == S_SHIFT_CLK);
    assign panel_lat   = (r_state == S_LATCH);
    assign panel_oe_n  = (r_state != S_DISPLAY);
    // Gated by rst so the pulse only appears once the block is actually running.
    assign frame_start = !rst && (r_state == S_ADDR_TOP) && (r_row == 4'd0)
                         && (r_plane == 3'd0) && (r_col == 6'd0);

endmodule

// File: tb/tb_hub75_scanner.sv
// Scoreboard bench for hub75_scanner: default instance checked against a queued
// reference model, plus a PWM_BITS=1/BCM_BASE=4 instance checked by position tracking.
module tb_hub75_scanner;

    localparam int PWM0 = 4;
    localparam int BASE0 = 32;
    localparam int PWM1 = 1;
    localparam int BASE1 = 4;
    localparam int FRAME0 = 24192;
    localparam int FRAME1 = 4192;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [11:0] addr0, addr1;
    logic [23:0] data0, data1;
    logic r1_0, g1_0, b1_0, r2_0, g2_0, b2_0;
    logic r1_1, g1_1, b1_1, r2_1, g2_1, b2_1;
    logic [3:0] rs0, rs1;
    logic pclk0, lat0, oe0, fs0;
    logic pclk1, lat1, oe1, fs1;

    logic [23:0] mem [0:2047];

    assign data0 = mem[addr0[10:0]];
    assign data1 = mem[addr1[10:0]];

    always #5 clk = ~clk;

    hub75_scanner #(.PWM_BITS(PWM0), .BCM_BASE(BASE0)) u_dut0 (
        .clk(clk), .rst(rst), .pixel_addr(addr0), .pixel_data(data0),
        .r1(r1_0), .g1(g1_0), .b1(b1_0), .r2(r2_0), .g2(g2_0), .b2(b2_0),
        .row_sel(rs0), .panel_clk(pclk0), .panel_lat(lat0), .panel_oe_n(oe0),
        .frame_start(fs0)
    );

    hub75_scanner #(.PWM_BITS(PWM1), .BCM_BASE(BASE1)) u_dut1 (
        .clk(clk), .rst(rst), .pixel_addr(addr1), .pixel_data(data1),
        .r1(r1_1), .g1(g1_1), .b1(b1_1), .r2(r2_1), .g2(g2_1), .b2(b2_1),
        .row_sel(rs1), .panel_clk(pclk1), .panel_lat(lat1), .panel_oe_n(oe1),
        .frame_start(fs1)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bit (8-PWM)+plane of each channel, top pixel row, bottom row+16.
    function automatic logic [5:0] exp_rgb(input int row, input int plane, input int col);
        int bi, t, b;
        bi = 8 - PWM0 + plane;
        t = int'(mem[row * 64 + col]);
        b = int'(mem[(row + 16) * 64 + col]);
        return 6'((((t >> (16 + bi)) & 1) << 5) | (((t >> (8 + bi)) & 1) << 4) |
                  (((t >> bi) & 1) << 3) | (((b >> (16 + bi)) & 1) << 2) |
                  (((b >> (8 + bi)) & 1) << 1) | ((b >> bi) & 1));
    endfunction

    logic [5:0] q_col[$];
    int q_disp[$];

    task automatic push_expect(input int frames);
        for (int f = 0; f < frames; f++)
            for (int row = 0; row < 16; row++)
                for (int plane = 0; plane < PWM0; plane++) begin
                    for (int col = 0; col < 64; col++)
                        q_col.push_back(exp_rgb(row, plane, col));
                    q_disp.push_back(row * 16 + plane);
                end
    endtask

    int cyc = 0;
    int lat_count = 0, rises0 = 0, run0 = 0, last_fs0 = -1, r2_ones = 0;
    logic [3:0] prev_rs0 = '0;
    logic pend_valid = 1'b0;
    logic [11:0] pend = '0;
    int seen_14a = 0;
    int c1 = 0, row1 = 0, run1 = 0, last_fs1 = -1;
    logic [5:0] e;
    int dent;
    int t1, b1v;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q_col.delete();
            q_disp.delete();
            lat_count = 0; rises0 = 0; run0 = 0; last_fs0 = -1; r2_ones = 0;
            prev_rs0 = '0; pend_valid = 1'b0;
            c1 = 0; row1 = 0; run1 = 0; last_fs1 = -1;
        end else begin
            if (pclk0) begin
                if (q_col.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL col_queue: panel_clk rise with no expected column data");
                end else begin
                    e = q_col.pop_front();
                    check("col_rgb", {26'd0, r1_0, g1_0, b1_0, r2_0, g2_0, b2_0}, {26'd0, e});
                end
                if (r2_0) r2_ones++;
                rises0++;
            end
            if (lat0) begin
                check("rises_between_latches", rises0, 64);
                rises0 = 0;
                lat_count++;
            end
            if (rs0 != prev_rs0) check("row_sel_change_window", {30'd0, lat0, oe0}, 32'd3);
            prev_rs0 = rs0;
            if (!oe0) run0++;
            else if (run0 > 0) begin
                if (q_disp.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL disp_queue: display window with no expected plane");
                end else begin
                    dent = q_disp.pop_front();
                    check("oe_low_len", run0, BASE0 << (dent % 16));
                    check("row_sel_disp", {28'd0, rs0}, dent / 16);
                end
                run0 = 0;
            end
            if (fs0) begin
                if (last_fs0 >= 0) check("frame_period", cyc - last_fs0, FRAME0);
                last_fs0 = cyc;
            end
            if (pend_valid) begin
                check("addr_bottom", {20'd0, addr0}, {20'd0, pend | 12'h400});
                if (pend == 12'h14A && addr0 == 12'h54A) seen_14a = 1;
                pend_valid = 1'b0;
            end else if (!addr0[10]) begin
                check("addr_bit11", {31'd0, addr0[11]}, 32'd0);
                pend = addr0;
                pend_valid = 1'b1;
            end
            // Small instance: single plane on bit 7, 4-cycle display, 4192-cycle frame.
            if (pclk1) begin
                t1 = int'(mem[row1 * 64 + c1]);
                b1v = int'(mem[(row1 + 16) * 64 + c1]);
                check("d1_rgb", {26'd0, r1_1, g1_1, b1_1, r2_1, g2_1, b2_1},
                      {26'd0, t1[23], t1[15], t1[7], b1v[23], b1v[15], b1v[7]});
                c1++;
            end
            if (lat1) begin
                check("d1_rises", c1, 64);
                check("d1_row_sel", {28'd0, rs1}, row1);
                c1 = 0;
                row1 = (row1 + 1) % 16;
            end
            if (!oe1) run1++;
            else if (run1 > 0) begin
                check("d1_oe_low_len", run1, BASE1);
                run1 = 0;
            end
            if (fs1) begin
                if (last_fs1 >= 0) check("d1_frame_period", cyc - last_fs1, FRAME1);
                last_fs1 = cyc;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, {20'd0, addr0}, 0);
        check({tag, "_rgb"}, {26'd0, r1_0, g1_0, b1_0, r2_0, g2_0, b2_0}, 0);
        check({tag, "_row_sel"}, {28'd0, rs0}, 0);
        check({tag, "_ctrl"}, {28'd0, pclk0, lat0, oe0, fs0}, 32'b0010);
        check({tag, "_d1_oe"}, {31'd0, oe1}, 1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 24'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        push_expect(2);
        rst = 1'b0;
        #1;
        check("release_frame_start", {31'd0, fs0}, 1);
        check("release_addr", {20'd0, addr0}, 0);

        // Run into frame 2 until row 7 plane 2 has been latched (latch index 94).
        for (int c = 0; c < 40000 && lat_count < 95; c++) @(posedge clk);
        #1;
        check("reach_row7_plane2", (lat_count >= 95) ? 32'd1 : 32'd0, 1);
        repeat (10) @(posedge clk);
        #1;
        check("in_display_before_abort", {31'd0, oe0}, 0);
        check("row_sel_before_abort", {28'd0, rs0}, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("abort");

        // Only ROW 17 has R=0x80: r2 must light for row 1, plane 3 only.
        for (int i = 0; i < 2048; i++) mem[i] = (i / 64 == 17) ? 24'h800000 : 24'h000000;
        push_expect(1);
        rst = 1'b0;
        #1;
        check("restart_frame_start", {31'd0, fs0}, 1);
        check("restart_addr", {20'd0, addr0}, 0);
        repeat (3200) @(posedge clk);
        #1;
        check("r2_ones_row17", r2_ones, 64);
        check("seen_addr_14a_54a", seen_14a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
